// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks a register range through one read port and streams each value with its index
module regfile_dump_reader #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
) (
    input  logic              clock,
    input  logic              ctrl_reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [IDX_W-1:0]  first_reg,
    input  logic [IDX_W-1:0]  last_reg,
    output logic [IDX_W-1:0]  rd_sel,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;
    state_t state, state_nx;
    logic [IDX_W-1:0] cnt, last_q;
    logic accept, reject, hs, kill;
    assign rd_sel = cnt;
    always_comb begin
        accept   = state == IDLE && start && first_reg <= last_reg;
        reject   = state == IDLE && start && first_reg > last_reg;
        kill     = state != IDLE && abort;
        hs       = state == HOLD && out_valid && out_ready;
        busy     = state == FETCH || state == HOLD;
        done     = state == DONE;
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? FETCH : IDLE;
            FETCH:   state_nx = HOLD;
            HOLD:    state_nx = hs ? (out_last ? DONE : FETCH) : HOLD;
            default: state_nx = IDLE;
        endcase
        if (kill) state_nx = IDLE;
    end
    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            last_q    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_nx;
            err   <= reject;
            if (accept) begin
                cnt    <= first_reg;
                last_q <= last_reg;
            end
            if (state == FETCH && !kill) begin
                out_data  <= rd_data;
                out_index <= cnt;
                out_last  <= cnt == last_q;
                out_valid <= 1'b1;
            end
            // the last check precedes the increment, so index 31 never wraps to 0
            if (hs && !out_last && !kill) cnt <= cnt + 1'b1;
            if (hs || kill) out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: directed stimulus with a scoreboard of expected stream words
module tb_regfile_dump_reader;
    logic        clock = 1'b0;
    logic        ctrl_reset_n, start, abort, out_ready;
    logic [4:0]  first_reg, last_reg, rd_sel, out_index;
    logic [31:0] rd_data, out_data;
    logic        out_valid, out_last, busy, done, err;
    logic [31:0] regs [32];
    typedef struct {logic [4:0] idx; logic [31:0] data; logic last;} word_t;
    word_t q[$];
    int vectors = 0, miscompares = 0;
    int cyc = 0, prev_hs_cyc = 0;
    bit prev_hs_valid = 0, spacing_chk = 0;
    logic exp_done = 1'b0;

    regfile_dump_reader dut (
        .clock(clock), .ctrl_reset_n(ctrl_reset_n), .start(start), .abort(abort),
        .first_reg(first_reg), .last_reg(last_reg), .rd_sel(rd_sel), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;
    assign rd_data = rd_sel == 5'd0 ? 32'd0 : regs[rd_sel];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic dump(input logic [4:0] f, input logic [4:0] l);
        for (int i = f; i <= l; i++)
            q.push_back('{idx: 5'(i), data: (i == 0) ? 32'd0 : 32'hA000_0000 + i, last: i == l});
        first_reg = f;
        last_reg  = l;
        start     = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done; i++) tick();
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    // scoreboard: every valid word must match the queue head until it is accepted
    always @(negedge clock) begin
        word_t e;
        if (out_valid) begin
            vectors++;
            assert (q.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_word observed_index=%0d expected=none", out_index);
            end
            if (q.size() != 0) begin
                e = q[0];
                chk("word_index", {27'd0, out_index}, {27'd0, e.idx});
                chk("word_data", out_data, e.data);
                chk("word_last", {31'd0, out_last}, {31'd0, e.last});
                if (out_ready && ctrl_reset_n && !abort) begin
                    void'(q.pop_front());
                    if (spacing_chk && prev_hs_valid) chk("word_spacing", cyc - prev_hs_cyc, 32'd2);
                    prev_hs_valid = !e.last;
                    prev_hs_cyc   = cyc;
                end
            end
        end
        chk("done_timing", {31'd0, done}, {31'd0, exp_done});
        exp_done = out_valid && out_ready && out_last && !abort && ctrl_reset_n;
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 + i;
        ctrl_reset_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        first_reg = '0; last_reg = '0;
        tick(); tick();
        ctrl_reset_n = 1'b1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rd_sel", {27'd0, rd_sel}, 32'd0);
        chk("rst_data", out_data, 32'd0);

        // minimum dump timing
        out_ready = 1'b1;
        dump(5'd12, 5'd12);
        chk("min_busy_c1", {31'd0, busy}, 32'd1);
        chk("min_valid_c1", {31'd0, out_valid}, 32'd0);
        tick();
        chk("min_valid_c2", {31'd0, out_valid}, 32'd1);
        chk("min_rd_sel", {27'd0, rd_sel}, 32'd12);
        tick();
        chk("min_done_c3", {31'd0, done}, 32'd1);
        chk("min_busy_c3", {31'd0, busy}, 32'd0);
        tick();
        chk("min_done_c4", {31'd0, done}, 32'd0);

        // full dump at peak rate
        spacing_chk = 1'b1; prev_hs_valid = 1'b0;
        dump(5'd0, 5'd31);
        wait_done(100);
        spacing_chk = 1'b0;
        chk("full_queue_empty", q.size(), 32'd0);
        tick(); tick();
        chk("full_no_wrap", {31'd0, out_valid}, 32'd0);

        // backpressure
        dump(5'd5, 5'd7);
        for (int i = 0; i < 200 && !done; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        out_ready = 1'b1;
        chk("bp_done_seen", {31'd0, done}, 32'd1);
        chk("bp_queue_empty", q.size(), 32'd0);
        tick();

        // rejected start
        first_reg = 5'd9; last_reg = 5'd3; start = 1'b1;
        tick();
        start = 1'b0;
        chk("rej_err", {31'd0, err}, 32'd1);
        chk("rej_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("rej_err_off", {31'd0, err}, 32'd0);
        chk("rej_valid", {31'd0, out_valid}, 32'd0);

        // start ignored mid-dump
        dump(5'd0, 5'd3);
        tick(); tick();
        first_reg = 5'd20; last_reg = 5'd25; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(40);
        chk("ign_queue_empty", q.size(), 32'd0);
        tick(); tick(); tick();

        // abort in HOLD at index 2
        out_ready = 1'b0;
        dump(5'd0, 5'd10);
        for (int i = 0; i < 60 && !(out_valid && out_index == 5'd2); i++) begin
            out_ready = out_valid;
            tick();
        end
        out_ready = 1'b0;
        chk("abort_at_idx", {27'd0, out_index}, 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        q.delete();
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        tick(); tick();
        out_ready = 1'b1;
        dump(5'd4, 5'd4);
        wait_done(20);
        chk("abort_restart_empty", q.size(), 32'd0);
        tick();

        // reset mid-dump
        dump(5'd0, 5'd10);
        repeat (4) tick();
        ctrl_reset_n = 1'b0;
        tick();
        ctrl_reset_n = 1'b1;
        q.delete();
        chk("mrst_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_data", out_data, 32'd0);
        chk("mrst_index", {27'd0, out_index}, 32'd0);
        chk("mrst_last", {31'd0, out_last}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd0);
        chk("mrst_rd_sel", {27'd0, rd_sel}, 32'd0);
        dump(5'd30, 5'd31);
        wait_done(20);
        chk("mrst_queue_empty", q.size(), 32'd0);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
